fc_weight_loader: RTL and testbench

//  Sequences configuration of fully_connected_layer: accepts a word stream of weights+biases,

---
 rtl/fc_ctrl_pkg.sv | 18 +
 rtl/fc_frame_tracker.sv | 32 +++
 rtl/fc_weight_loader.sv | 175 +++++++++++++++++
 tb/tb_fc_weight_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_ctrl_pkg.sv
// Shared types and helpers for the fully_connected_layer control blocks.
package fc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        LOAD_W = 3'd2,
        LOAD_B = 3'd3,
        DONE   = 3'd4
    } e_ld_state;

    // Words in one load image: every neuron ROM plus one bias per neuron.
    function automatic int unsigned fc_load_words(input int unsigned in_dim,
                                                  input int unsigned out_dim);
        return out_dim * (in_dim + 32'd1);
    endfunction

endpackage

// File: rtl/fc_frame_tracker.sv
// Tracks whether a sop..eop frame is in flight on a valid/ready pixel stream.
module fc_frame_tracker
    import fc_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en,
    input  logic valid,
    input  logic ready,
    input  logic sop,
    input  logic eop,
    output logic in_frame
);

    logic in_frame_r;

    // Frame flag: eop wins, so a single-beat sop+eop frame leaves the flag clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_frame_r <= 1'b0;
        end else if (clk_en && valid && ready) begin
            if (eop) begin
                in_frame_r <= 1'b0;
            end else if (sop) begin
                in_frame_r <= 1'b1;
            end
        end
    end

    assign in_frame = in_frame_r;

endmodule

// File: rtl/fc_weight_loader.sv
// Streams a weight+bias image into fully_connected_layer and holds off pixel
// frames while a reload is pending or in progress.
module fc_weight_loader
    import fc_ctrl_pkg::*;
#(
    parameter int PIX_WIDTH     = 16,
    parameter int IN_DIMENSION  = 200,
    parameter int OUT_DIMENSION = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clk_en,
    input  logic                               load_req,
    input  logic [31:0]                        s_data,
    input  logic                               s_valid,
    input  logic                               s_last,
    output logic                               s_ready,
    output logic [31:0]                        weights_mem_in_data,
    output logic [$clog2(IN_DIMENSION)-1:0]    weights_mem_in_addr,
    output logic [$clog2(OUT_DIMENSION):0]     weights_mem_sel_addr,
    output logic                               weights_mem_in_fc_wr,
    input  logic [PIX_WIDTH-1:0]               up_data,
    input  logic                               up_valid,
    input  logic                               up_sop,
    input  logic                               up_eop,
    output logic                               up_ready,
    output logic [PIX_WIDTH-1:0]               fc_data,
    output logic                               fc_valid,
    output logic                               fc_sop,
    output logic                               fc_eop,
    input  logic                               fc_ready,
    output logic                               loaded,
    output logic                               load_done,
    output logic                               load_err
);

    localparam int AW = $clog2(IN_DIMENSION);
    localparam int SW = $clog2(OUT_DIMENSION) + 1;
    localparam logic [AW-1:0] ADDR_W_LAST = AW'(IN_DIMENSION - 1);
    localparam logic [AW-1:0] ADDR_B_LAST = AW'(OUT_DIMENSION - 1);
    localparam logic [SW-1:0] SEL_W_LAST  = SW'(OUT_DIMENSION - 1);
    localparam logic [SW-1:0] SEL_BIAS    = SW'(OUT_DIMENSION);

    e_ld_state     state_r;
    e_ld_state     state_nxt_s;
    logic [AW-1:0] addr_r;
    logic [SW-1:0] sel_r;
    logic          wr_r;
    logic [31:0]   wdata_r;
    logic [AW-1:0] waddr_r;
    logic [SW-1:0] wsel_r;
    logic          loaded_r;
    logic          load_done_r;
    logic          load_err_r;
    logic          in_frame_s;
    logic          loading_s;
    logic          accept_s;
    logic          last_word_s;
    logic          pass_en_s;

    assign loading_s   = (state_r == LOAD_W) || (state_r == LOAD_B);
    assign s_ready     = clk_en & loading_s;
    assign accept_s    = s_valid & s_ready;
    assign last_word_s = (sel_r == SEL_BIAS) && (addr_r == ADDR_B_LAST);

    // Frames already started may finish; no new frame starts once a reload is pending.
    assign pass_en_s = loaded_r & ~((state_r != IDLE) & ~in_frame_s);
    assign fc_valid  = up_valid & pass_en_s;
    assign up_ready  = fc_ready & pass_en_s;
    assign fc_data   = up_data;
    assign fc_sop    = up_sop;
    assign fc_eop    = up_eop;

    fc_frame_tracker u_frame_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .valid    (up_valid),
        .ready    (up_ready),
        .sop      (up_sop),
        .eop      (up_eop),
        .in_frame (in_frame_s)
    );

    // Load sequencer next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (load_req) state_nxt_s = DRAIN; else state_nxt_s = IDLE;
            DRAIN:   if (!in_frame_s && fc_ready) state_nxt_s = LOAD_W; else state_nxt_s = DRAIN;
            LOAD_W:  if (accept_s && sel_r == SEL_W_LAST && addr_r == ADDR_W_LAST) state_nxt_s = LOAD_B;
                     else state_nxt_s = LOAD_W;
            LOAD_B:  if (accept_s && last_word_s) state_nxt_s = DONE; else state_nxt_s = LOAD_B;
            DONE:    if (load_req) state_nxt_s = DRAIN; else state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Load sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else if (clk_en) begin
            state_r <= state_nxt_s;
        end
    end

    // ROM/bias address counters; addr wraps when the neuron select advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r <= {AW{1'b0}};
            sel_r  <= {SW{1'b0}};
        end else if (clk_en) begin
            if (state_r == DRAIN) begin
                addr_r <= {AW{1'b0}};
                sel_r  <= {SW{1'b0}};
            end else if (accept_s) begin
                if (sel_r != SEL_BIAS && addr_r == ADDR_W_LAST) begin
                    addr_r <= {AW{1'b0}};
                    sel_r  <= sel_r + SW'(1);
                end else begin
                    addr_r <= addr_r + AW'(1);
                end
            end
        end
    end

    // Registered write port: one write per accepted word, one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_r    <= 1'b0;
            wdata_r <= 32'd0;
            waddr_r <= {AW{1'b0}};
            wsel_r  <= {SW{1'b0}};
        end else if (clk_en) begin
            wr_r <= accept_s;
            if (accept_s) begin
                wdata_r <= s_data;
                waddr_r <= addr_r;
                wsel_r  <= sel_r;
            end
        end
    end

    // Status flags: loaded, load_done pulse and sticky framing error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loaded_r    <= 1'b0;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else if (clk_en) begin
            load_done_r <= (state_r == DONE);
            if (state_r == DONE) begin
                loaded_r <= 1'b1;
            end else if (state_r == DRAIN && state_nxt_s == LOAD_W) begin
                loaded_r <= 1'b0;
            end
            if (load_req && !loading_s) begin
                load_err_r <= 1'b0;
            end else if (accept_s && (s_last != last_word_s)) begin
                load_err_r <= 1'b1;
            end
        end
    end

    // A frozen cycle must never repeat a write, so the strobe is masked by clk_en.
    assign weights_mem_in_fc_wr = wr_r & clk_en;
    assign weights_mem_in_data  = wdata_r;
    assign weights_mem_in_addr  = waddr_r;
    assign weights_mem_sel_addr = wsel_r;
    assign loaded               = loaded_r;
    assign load_done            = load_done_r;
    assign load_err             = load_err_r;

endmodule

// File: tb/tb_fc_weight_loader.sv
// Randomized bench for fc_weight_loader with a small dimension (4 inputs, 2 neurons).
module tb_fc_weight_loader;

    localparam int PW = 16;
    localparam int ID = 4;
    localparam int OD = 2;
    localparam int N  = OD * (ID + 1);
    localparam int AW = $clog2(ID);
    localparam int SW = $clog2(OD) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_en = 1'b1;
    logic          load_req = 1'b0;
    logic [31:0]   s_data = 32'd0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [31:0]   wdata;
    logic [AW-1:0] waddr;
    logic [SW-1:0] wsel;
    logic          wr;
    logic [PW-1:0] up_data = '0;
    logic          up_valid = 1'b0;
    logic          up_sop = 1'b0;
    logic          up_eop = 1'b0;
    logic          up_ready;
    logic [PW-1:0] fc_data;
    logic          fc_valid;
    logic          fc_sop;
    logic          fc_eop;
    logic          fc_ready = 1'b1;
    logic          loaded;
    logic          load_done;
    logic          load_err;

    typedef struct {
        logic [SW-1:0] sel;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         wq[$];
    int          ld_cnt = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_data [N];
    int          wbase;
    int          lbase;

    fc_weight_loader #(.PIX_WIDTH(PW), .IN_DIMENSION(ID), .OUT_DIMENSION(OD)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .load_req(load_req),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .weights_mem_in_data(wdata), .weights_mem_in_addr(waddr),
        .weights_mem_sel_addr(wsel), .weights_mem_in_fc_wr(wr),
        .up_data(up_data), .up_valid(up_valid), .up_sop(up_sop), .up_eop(up_eop),
        .up_ready(up_ready), .fc_data(fc_data), .fc_valid(fc_valid), .fc_sop(fc_sop),
        .fc_eop(fc_eop), .fc_ready(fc_ready), .loaded(loaded), .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Observe the layer write port and the done pulse away from the active edge.
    always @(negedge clk) begin
        if (wr === 1'b1) wq.push_back('{wsel, waddr, wdata});
        if (load_done === 1'b1) ld_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_image();
        for (int k = 0; k < N; k++) exp_data[k] = $urandom();
        wbase = wq.size();
        lbase = ld_cnt;
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        @(negedge clk);
        total++;
        if (load_err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear_on_req: load_err=%b want 0", load_err);
        end
        tick();
    endtask

    // Offer words 0..n-1; optionally freeze clk_en for 3 cycles after word freeze_at-1.
    task automatic stream(input int n, input int last_idx, input bit rnd, input int freeze_at);
        int  k = 0;
        int  cyc = 0;
        bit  acc;
        while (k < n && cyc < 400) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = exp_data[k];
            s_last  = (k == last_idx);
            @(negedge clk);
            if (up_valid === 1'b1) begin
                total++;
                if (up_ready !== 1'b0 || fc_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL px_blocked_in_load: up_ready=%b fc_valid=%b want 0 0", up_ready, fc_valid);
                end
            end
            acc = s_valid && (s_ready === 1'b1);
            tick();
            if (acc) begin
                k++;
                if (k == freeze_at) begin
                    s_valid = 1'b0;
                    clk_en  = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        total++;
                        if (wr !== 1'b0 || s_ready !== 1'b0) begin
                            bad++;
                            $display("FAIL frozen: wr=%b s_ready=%b want 0 0", wr, s_ready);
                        end
                        tick();
                    end
                    clk_en = 1'b1;
                end
            end
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        total++;
        if (k != n) begin
            bad++;
            $display("FAIL stream_timeout: accepted=%0d want %0d", k, n);
        end
    endtask

    // Wait for completion and compare the write trace against the load-order model.
    task automatic check_load(input logic exp_err);
        int cyc = 0;
        int nw;
        int es;
        int ea;
        while (ld_cnt == lbase && cyc < 20) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        total++;
        if (ld_cnt - lbase != 1) begin
            bad++;
            $display("FAIL load_done_count: got %0d want 1", ld_cnt - lbase);
        end
        total++;
        if (loaded !== 1'b1) begin
            bad++;
            $display("FAIL loaded: got %b want 1", loaded);
        end
        total++;
        if (load_err !== exp_err) begin
            bad++;
            $display("FAIL load_err: got %b want %b", load_err, exp_err);
        end
        nw = wq.size() - wbase;
        total++;
        if (nw != N) begin
            bad++;
            $display("FAIL write_count: got %0d want %0d", nw, N);
        end
        for (int k = 0; k < N && k < nw; k++) begin
            if (k < OD * ID) begin
                es = k / ID;
                ea = k % ID;
            end else begin
                es = OD;
                ea = k - OD * ID;
            end
            total++;
            if (int'(wq[wbase+k].sel) != es || int'(wq[wbase+k].addr) != ea ||
                wq[wbase+k].data !== exp_data[k]) begin
                bad++;
                $display("FAIL write_%0d: sel=%0d addr=%0d data=%h want sel=%0d addr=%0d data=%h",
                         k, wq[wbase+k].sel, wq[wbase+k].addr, wq[wbase+k].data, es, ea, exp_data[k]);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        total++;
        if ({s_ready, wr, fc_valid, up_ready, loaded, load_done, load_err} !== 7'd0) begin
            bad++;
            $display("FAIL %s: s_ready=%b wr=%b fc_valid=%b up_ready=%b loaded=%b done=%b err=%b want all 0",
                     tag, s_ready, wr, fc_valid, up_ready, loaded, load_done, load_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b1; up_valid = 1'b1; fc_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_idle_outputs("reset_outputs");
        total++;
        if ({wsel, waddr, wdata} !== '0) begin
            bad++;
            $display("FAIL reset_wport: sel=%0d addr=%0d data=%h want 0", wsel, waddr, wdata);
        end
        tick();
        rst_n = 1'b1;
        s_valid = 1'b0;
    endtask

    task automatic test_no_pass_before_load();
        up_sop = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (fc_valid !== 1'b0 || up_ready !== 1'b0) begin
                bad++;
                $display("FAIL no_pass_unloaded: fc_valid=%b up_ready=%b want 0 0", fc_valid, up_ready);
            end
            tick();
        end
        up_valid = 1'b0; up_sop = 1'b0;
    endtask

    task automatic test_basic_load();
        fill_image();
        for (int k = 0; k < N; k++) exp_data[k] = 32'(k);
        pulse_req();
        stream(N, N - 1, 1'b0, -1);
        check_load(1'b0);
    endtask

    task automatic pix_check(input string tag, input logic exp_rdy, input logic exp_vld);
        @(negedge clk);
        total++;
        if (up_ready !== exp_rdy || fc_valid !== exp_vld ||
            (exp_vld && (fc_data !== up_data || fc_sop !== up_sop || fc_eop !== up_eop))) begin
            bad++;
            $display("FAIL %s: up_ready=%b fc_valid=%b fc_data=%h want %b %b %h",
                     tag, up_ready, fc_valid, fc_data, exp_rdy, exp_vld, up_data);
        end
    endtask

    task automatic test_drain();
        fill_image();
        fc_ready = 1'b1; up_valid = 1'b1; up_sop = 1'b1; up_eop = 1'b0; up_data = PW'($urandom());
        pix_check("frame_sop", 1'b1, 1'b1);
        tick();
        up_sop = 1'b0; up_data = PW'($urandom()); load_req = 1'b1;
        pix_check("frame_mid", 1'b1, 1'b1);
        tick();
        load_req = 1'b0; up_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (s_ready !== 1'b0) begin
                bad++;
                $display("FAIL drain_hold: s_ready=%b want 0", s_ready);
            end
            tick();
        end
        up_valid = 1'b1; up_eop = 1'b1; up_data = PW'($urandom()); fc_ready = 1'b0;
        pix_check("eop_stalled", 1'b0, 1'b1);
        tick();
        fc_ready = 1'b1;
        pix_check("frame_eop", 1'b1, 1'b1);
        tick();
        up_sop = 1'b1; up_eop = 1'b0; up_data = PW'($urandom()); fc_ready = 1'b0;
        pix_check("new_sop_blocked", 1'b0, 1'b0);
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL drain_wait_ready: s_ready=%b want 0", s_ready);
        end
        tick();
        fc_ready = 1'b1;
        stream(N, N - 1, 1'b0, -1);
        check_load(1'b0);
        pix_check("sop_after_load", 1'b1, 1'b1);
        tick();
        up_sop = 1'b0; up_eop = 1'b1;
        tick();
        up_valid = 1'b0; up_eop = 1'b0;
    endtask

    task automatic test_toggle_freeze();
        fill_image();
        pulse_req();
        stream(N, N - 1, 1'b1, 5);
        check_load(1'b0);
    endtask

    task automatic test_err();
        fill_image();
        pulse_req();
        stream(N, 6, 1'b1, -1);
        check_load(1'b1);
        fill_image();
        pulse_req();
        stream(N, N - 1, 1'b1, -1);
        check_load(1'b0);
    endtask

    task automatic test_reset_mid();
        fill_image();
        pulse_req();
        stream(5, N - 1, 1'b0, -1);
        rst_n = 1'b0; up_valid = 1'b1; fc_ready = 1'b1;
        tick();
        @(negedge clk);
        check_idle_outputs("reset_mid_load");
        tick();
        rst_n = 1'b1; up_valid = 1'b0;
        tick();
        fill_image();
        pulse_req();
        stream(N, N - 1, 1'b1, -1);
        check_load(1'b0);
    endtask

    initial begin
        test_reset();
        test_no_pass_before_load();
        test_basic_load();
        test_drain();
        test_toggle_freeze();
        test_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
